fetch_mem_arbiter: RTL and testbench

Sequential arbiter sharing one single-port, variable-latency memory between the instruction-fetch stage and the data-memory stage. Each requester holds a level request until it receives a one-cycle valid pulse. The arbiter drives a registered memory request and returns the read data in a registered buffer. Its stall outputs feed the pipeline freeze logic, so fetch and data access never collide on the memory port.

---
 rtl/fetch_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_fetch_mem_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_mem_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch and data access; data has priority.
// Define FETCH_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT consecutive data grants.
module fetch_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, RESP} state_t;

  state_t            state_q;
  logic              mem_req_q, mem_we_q, if_valid_q, d_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
  logic              d_pend, grant_d, grant_i;

`ifdef FETCH_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_q, starve_d;
`else
  localparam int starve_limit_unused = STARVE_LIMIT;
`endif

  always_comb begin
    d_pend  = d_rd | d_wr;
    grant_d = d_pend;
    grant_i = ~d_pend & if_req;
`ifdef FETCH_ARB_STARVE_GUARD_EN
    // Fetch has waited through LIMIT data grants: it wins this round.
    if (if_req && starve_q == LIMIT) begin
      grant_d = 1'b0;
      grant_i = 1'b1;
    end
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (grant_i)
        starve_d = '0;
      else if (grant_d)
        starve_d = if_req ? starve_q + 1'b1 : '0;
    end
`endif
  end

`ifdef FETCH_ARB_STARVE_GUARD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_wr;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            state_q     <= D_ACC;
          end else if (grant_i) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr;
            state_q    <= I_ACC;
          end
        end
        D_ACC: begin
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (!mem_we_q) d_rdata_q <= mem_rdata;
            d_valid_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        I_ACC: begin
          if (mem_ready) begin
            mem_req_q  <= 1'b0;
            if_rdata_q <= mem_rdata;
            if_valid_q <= 1'b1;
            state_q    <= RESP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign d_stall   = d_pend & ~d_valid_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter: reset, fetch, data-first priority, stretched write,
// reset abort, idle mem_ready, and the data/fetch grant pattern under saturation.
module tb_fetch_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_rd, d_wr, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, if_stall, d_valid, d_stall, mem_req, mem_we;

  int vec  = 0;
  int errs = 0;

  fetch_mem_arbiter dut (
    .clk(clk), .rst(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    logic exp_fetch;
    rst_n = 1'b0;
    if_req = 0; d_rd = 0; d_wr = 0; mem_ready = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_valids", {if_valid, d_valid}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    rst_n = 1'b1;
    tick();

    // Single fetch with memory always ready
    if_req = 1; if_addr = 32'h10; mem_ready = 1; mem_rdata = 32'h1234_5678;
    #1 chk("f_stall_idle", if_stall, 1);
    tick();
    chk("f_mem_req", mem_req, 1);
    chk("f_mem_addr", mem_addr, 32'h10);
    chk("f_mem_we", mem_we, 0);
    chk("f_stall_acc", if_stall, 1);
    chk("f_no_valid_acc", if_valid, 0);
    tick();
    chk("f_valid", if_valid, 1);
    chk("f_rdata", if_rdata, 32'h1234_5678);
    chk("f_stall_valid", if_stall, 0);
    chk("f_req_drop", mem_req, 0);
    chk("f_no_dvalid", d_valid, 0);
    if_req = 0;
    tick();
    chk("f_valid_pulse", if_valid, 0);

    // mem_ready held high in IDLE with no request
    mem_rdata = 32'hCAFE_0000;
    tick(); tick();
    chk("idle_ready_req", mem_req, 0);
    chk("idle_ready_valid", {if_valid, d_valid}, 0);
    chk("idle_ready_rdata", if_rdata, 32'h1234_5678);

    // Data and fetch together: data first, fetch follows
    d_rd = 1; if_req = 1; d_addr = 32'h40; if_addr = 32'h80; mem_rdata = 32'hA5A5_0001;
    tick();
    chk("p_addr_data", mem_addr, 32'h40);
    chk("p_stalls", {d_stall, if_stall}, 2'b11);
    tick();
    chk("p_dvalid", d_valid, 1);
    chk("p_drdata", d_rdata, 32'hA5A5_0001);
    chk("p_ivalid_early", if_valid, 0);
    chk("p_stalls_resp", {d_stall, if_stall}, 2'b01);
    d_rd = 0; mem_rdata = 32'h0B0B_0002;
    tick();
    chk("p_idle", {mem_req, d_valid, if_valid}, 0);
    tick();
    chk("p_addr_fetch", mem_addr, 32'h80);
    chk("p_fetch_we", mem_we, 0);
    tick();
    chk("p_ivalid", if_valid, 1);
    chk("p_irdata", if_rdata, 32'h0B0B_0002);
    chk("p_drdata_kept", d_rdata, 32'hA5A5_0001);
    if_req = 0;
    tick();

    // Write with 5 wait states; inputs changed mid-access must not leak
    mem_ready = 0; d_wr = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; mem_rdata = 32'hFFFF_FFFF;
    tick();
    d_addr = 32'h99; d_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("w_hold", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h20, 32'hDEAD_BEEF});
      chk("w_no_valid", d_valid, 0);
      tick();
    end
    mem_ready = 1;
    tick();
    chk("w_dvalid", d_valid, 1);
    chk("w_drdata_kept", d_rdata, 32'hA5A5_0001);
    chk("w_req_drop", mem_req, 0);
    chk("w_dstall", d_stall, 0);
    d_wr = 0; mem_ready = 0;
    tick();

    // Reset in the second cycle of a fetch access
    if_req = 1; if_addr = 32'h30;
    tick();
    chk("a_req", mem_req, 1);
    tick();
    #2 rst_n = 1'b0;
    #1 chk("a_async_drop", mem_req, 0);
    chk("a_addr_clr", mem_addr, 0);
    tick();
    chk("a_no_valid", if_valid, 0);
    rst_n = 1'b1; mem_ready = 1; mem_rdata = 32'h77;
    tick();
    chk("a_restart_req", mem_req, 1);
    chk("a_restart_addr", mem_addr, 32'h30);
    tick();
    chk("a_restart_valid", if_valid, 1);
    chk("a_restart_rdata", if_rdata, 32'h77);
    if_req = 0;
    tick();

    // Saturated requesters: grant pattern over 15 accesses
    d_rd = 1; if_req = 1; d_addr = 32'h44; if_addr = 32'h88;
    k = 0;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (d_valid || if_valid) begin
`ifdef FETCH_ARB_STARVE_GUARD_EN
        exp_fetch = ((k % 5) == 4);
`else
        exp_fetch = 1'b0;
`endif
        chk($sformatf("s_grant_%0d", k), {if_valid, d_valid}, {exp_fetch, ~exp_fetch});
        k++;
      end
    end
    chk("s_count", k, 15);
    d_rd = 0; if_req = 0;
    tick(); tick();
    chk("s_quiet", {mem_req, d_valid, if_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
